// File: rtl/snn_noc_pkg.sv
// Shared NoC definitions: port count, destination field width and decode.
// Pure declarations, no latency or backpressure of its own.
package snn_noc_pkg;
    localparam int NUM_PORTS = 4;
    localparam int DEST_W    = 2;
    localparam int PKT_W     = 32;
    localparam int CNT_W     = 8;

    typedef logic [DEST_W-1:0] port_id_t;

    function automatic port_id_t dest_of(input logic [PKT_W-1:0] pkt);
        return pkt[PKT_W-1 -: DEST_W];
    endfunction
endpackage

// File: rtl/splitter_1_ip_4_op_if.sv
// Packet-in / four-ports-out valid-ready bundle for the splitter.
// Master drives in_* and out_ready; slave (the splitter) drives the rest.
interface splitter_1_ip_4_op_if
    import snn_noc_pkg::*;
#(
    parameter int WIDTH = PKT_W
);
    logic                          in_valid;
    logic                          in_ready;
    logic [WIDTH-1:0]              in_data;
    logic [NUM_PORTS-1:0]          out_valid;
    logic [NUM_PORTS-1:0]          out_ready;
    logic [NUM_PORTS*WIDTH-1:0]    out_data;
    logic [NUM_PORTS*CNT_W-1:0]    port_count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, port_count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, port_count
    );
endinterface

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO, registered write, head visible the cycle after a write.
// Caller must not write when full unless popping, nor read when empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Extra pointer MSB tells a full buffer apart from an empty one.
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/splitter_1_ip_4_op.sv
// Routes each packet by its top 2 bits to one of 4 output FIFOs; 2 cycles in-to-out, 1 pkt/cycle.
// Input stalls only when the FIFO of the packet held in the input register is full and not popping.
module splitter_1_ip_4_op
    import snn_noc_pkg::*;
#(
    parameter int WIDTH = PKT_W,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    splitter_1_ip_4_op_if.slave   bus
);
    logic                 ir_vld_q, ir_vld_d;
    logic [WIDTH-1:0]     ir_dat_q, ir_dat_d;
    logic [CNT_W-1:0]     cnt_q [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_d [NUM_PORTS];

    port_id_t             ir_dest;
    logic                 ir_move;
    logic                 accept;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] fifo_wr;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] can_write;
    logic [WIDTH-1:0]     fifo_rd_dat [NUM_PORTS];

    // A full FIFO still takes a write on the same edge it is popped.
    always_comb begin
        ir_dest   = dest_of(ir_dat_q);
        pop       = ~fifo_empty & bus.out_ready;
        can_write = ~fifo_full | pop;
        ir_move   = ir_vld_q && can_write[ir_dest];
        accept    = bus.in_valid && (!ir_vld_q || ir_move);
        fifo_wr   = '0;
        if (ir_move) begin
            fifo_wr[ir_dest] = 1'b1;
        end
        ir_vld_d  = accept || (ir_vld_q && !ir_move);
        ir_dat_d  = accept ? bus.in_data : ir_dat_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            cnt_d[p] = cnt_q[p] + CNT_W'(pop[p]);
        end
    end

    always_comb begin
        bus.in_ready   = !ir_vld_q || ir_move;
        bus.out_valid  = ~fifo_empty;
        bus.out_data   = '0;
        bus.port_count = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.out_data[p*WIDTH +: WIDTH]   = fifo_rd_dat[p];
            bus.port_count[p*CNT_W +: CNT_W] = cnt_q[p];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_vld_q <= 1'b0;
            ir_dat_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            ir_vld_q <= ir_vld_d;
            ir_dat_q <= ir_dat_d;
            cnt_q    <= cnt_d;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        sync_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (fifo_wr[p]),
            .wr_data (ir_dat_q),
            .rd_en   (pop[p]),
            .rd_data (fifo_rd_dat[p]),
            .full    (fifo_full[p]),
            .empty   (fifo_empty[p])
        );
    end
endmodule

// File: tb/tb_splitter_1_ip_4_op.sv
// Scoreboard bench for splitter_1_ip_4_op: accepted packets are queued per port, compared on delivery.
module tb_splitter_1_ip_4_op;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [W-1:0] sb [4][$];
    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_got;

    splitter_1_ip_4_op_if #(.WIDTH(W)) bus ();

    splitter_1_ip_4_op #(.WIDTH(W), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Handshakes are judged at the falling edge; they commit at the next rising edge.
    always @(negedge clk) begin
        if (reset == 1'b0) begin
            if (bus.in_valid && bus.in_ready) begin
                sb[bus.in_data[W-1 -: 2]].push_back(bus.in_data);
            end
            for (int p = 0; p < 4; p++) begin
                if (bus.out_valid[p] && bus.out_ready[p]) begin
                    mon_got = bus.out_data[p*W +: W];
                    checks++;
                    if (sb[p].size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected port=%0d got=%h expected=none", p, mon_got);
                    end else begin
                        mon_exp = sb[p].pop_front();
                        if (mon_got !== mon_exp) begin
                            failures++;
                            $display("FAIL sb_data port=%0d got=%h expected=%h", p, mon_got, mon_exp);
                        end
                    end
                end
            end
        end
    end

    function automatic int q_total();
        return sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
    endfunction

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'h0;
        reset = 1'b1;
        for (int p = 0; p < 4; p++) sb[p].delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] pkt);
        bus.in_valid = 1'b1;
        bus.in_data  = pkt;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        failures++;
        $display("FAIL send_timeout pkt=%h in_ready=%0b expected=1", pkt, bus.in_ready);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && q_total() != 0; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks += 4;
        if (bus.out_valid !== 4'h0) begin failures++; $display("FAIL rst_out_valid got=%b expected=0000", bus.out_valid); end
        if (bus.out_data !== '0) begin failures++; $display("FAIL rst_out_data got=%h expected=0", bus.out_data); end
        if (bus.port_count !== 32'h0) begin failures++; $display("FAIL rst_port_count got=%h expected=0", bus.port_count); end
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b expected=1", bus.in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [W-1:0] pk [4];
        logic [3:0]   ev;
        pk = '{32'h0000_0001, 32'h4000_0002, 32'h8000_0003, 32'hC000_0004};
        do_reset();
        bus.out_ready = 4'hF;
        for (int p = 0; p < 4; p++) begin
            send(pk[p]);
            @(posedge clk);
            #1;
            ev = 4'b0001 << p;
            checks += 2;
            if (bus.out_valid !== ev) begin failures++; $display("FAIL basic_valid port=%0d got=%b expected=%b", p, bus.out_valid, ev); end
            if (bus.out_data[p*W +: W] !== pk[p]) begin failures++; $display("FAIL basic_data port=%0d got=%h expected=%h", p, bus.out_data[p*W +: W], pk[p]); end
        end
        drain();
        checks++;
        if (bus.port_count !== 32'h0101_0101) begin failures++; $display("FAIL basic_count got=%h expected=01010101", bus.port_count); end
    endtask

    task automatic test_hol();
        do_reset();
        bus.out_ready = 4'b1011;
        for (int i = 1; i <= 5; i++) send(32'h8000_0000 | 32'(i));
        #1;
        checks += 2;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL hol_stall got=%b expected=0", bus.in_ready); end
        if (bus.out_data[2*W +: W] !== 32'h8000_0001) begin failures++; $display("FAIL hol_head got=%h expected=80000001", bus.out_data[2*W +: W]); end
        fork
            send(32'h0000_00A0);
            begin
                repeat (3) begin @(posedge clk); #2; end
                checks += 3;
                if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL hol_held_ready got=%b expected=0", bus.in_ready); end
                if (bus.out_valid[0] !== 1'b0) begin failures++; $display("FAIL hol_port0_held got=%b expected=0", bus.out_valid[0]); end
                if (bus.port_count[23:16] !== 8'd0) begin failures++; $display("FAIL hol_no_pop got=%0d expected=0", bus.port_count[23:16]); end
                bus.out_ready[2] = 1'b1;
            end
        join
        send(32'h8000_0006);
        drain();
        checks += 2;
        if (q_total() !== 0) begin failures++; $display("FAIL hol_drain left=%0d expected=0", q_total()); end
        if (bus.port_count !== 32'h0006_0001) begin failures++; $display("FAIL hol_count got=%h expected=00060001", bus.port_count); end
    endtask

    task automatic test_full_pop();
        do_reset();
        bus.out_ready = 4'b1101;
        for (int i = 1; i <= 5; i++) send(32'h4000_0010 + 32'(i));
        bus.out_ready[1] = 1'b1;
        bus.in_valid     = 1'b1;
        bus.in_data      = 32'h4000_0016;
        #1;
        checks += 2;
        if (bus.out_valid[1] !== 1'b1) begin failures++; $display("FAIL fp_valid got=%b expected=1", bus.out_valid[1]); end
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL fp_ready_pop got=%b expected=1", bus.in_ready); end
        @(posedge clk);
        #1;
        bus.out_ready[1] = 1'b0;
        bus.in_data      = 32'h4000_0017;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL fp_still_full got=%b expected=0", bus.in_ready); end
        bus.out_ready = 4'hF;
        send(32'h4000_0017);
        drain();
        checks += 2;
        if (q_total() !== 0) begin failures++; $display("FAIL fp_drain left=%0d expected=0", q_total()); end
        if (bus.port_count[15:8] !== 8'd7) begin failures++; $display("FAIL fp_count got=%0d expected=7", bus.port_count[15:8]); end
    endtask

    task automatic test_back_to_back();
        int gaps = 0;
        do_reset();
        bus.out_ready = 4'hF;
        for (int i = 0; i < 100; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = ((i % 2) != 0) ? (32'hC000_0000 | 32'(i)) : 32'(i);
            @(negedge clk);
            if (!bus.in_ready) gaps++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        drain();
        checks += 3;
        if (gaps !== 0) begin failures++; $display("FAIL b2b_gaps got=%0d expected=0", gaps); end
        if (bus.port_count[7:0] !== 8'd50) begin failures++; $display("FAIL b2b_count0 got=%0d expected=50", bus.port_count[7:0]); end
        if (bus.port_count[31:24] !== 8'd50) begin failures++; $display("FAIL b2b_count3 got=%0d expected=50", bus.port_count[31:24]); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.out_ready = 4'hF;
        for (int i = 0; i < 300; i++) send(32'h4000_0000 | 32'(i));
        drain();
        checks++;
        if (bus.port_count !== 32'h0000_2C00) begin failures++; $display("FAIL wrap_count got=%h expected=00002c00", bus.port_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready = 4'hF;
        send(32'h8000_0100);
        drain();
        bus.out_ready = 4'h0;
        send(32'h0000_0101);
        send(32'h8000_0102);
        send(32'h0000_0103);
        @(posedge clk);
        #1;
        checks += 2;
        if (bus.out_valid !== 4'b0101) begin failures++; $display("FAIL rm_pre_valid got=%b expected=0101", bus.out_valid); end
        if (bus.port_count !== 32'h0001_0000) begin failures++; $display("FAIL rm_pre_count got=%h expected=00010000", bus.port_count); end
        reset = 1'b1;
        for (int p = 0; p < 4; p++) sb[p].delete();
        #1;
        checks += 3;
        if (bus.out_valid !== 4'h0) begin failures++; $display("FAIL rm_async_valid got=%b expected=0000", bus.out_valid); end
        if (bus.port_count !== 32'h0) begin failures++; $display("FAIL rm_async_count got=%h expected=0", bus.port_count); end
        if (bus.out_data !== '0) begin failures++; $display("FAIL rm_async_data got=%h expected=0", bus.out_data); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bus.out_ready = 4'hF;
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (bus.out_valid !== 4'h0) begin failures++; $display("FAIL rm_stale got=%b expected=0000", bus.out_valid); end
        send(32'h4000_0104);
        drain();
        checks++;
        if (bus.port_count !== 32'h0000_0100) begin failures++; $display("FAIL rm_after got=%h expected=00000100", bus.port_count); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 4'h0;
        test_reset();
        test_basic();
        test_hol();
        test_full_pop();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
